// File: rtl/hamming_decode_s.sv
`default_nettype none
// hamming_decode_s: serial Hamming(7,4) receiver with single-error correction and idle timeout.
// Define HAMMING_SECDED_EN for the 8-bit extended (SECDED) frame with double-error detection.
module hamming_decode_s (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       d_in,
    input  logic       strobe_in,
    output logic [3:0] data_out,
    output logic       valid_out,
    output logic [2:0] err_pos,
    output logic       err_corr,
    output logic       err_dbl,
    output logic       frame_abort
);

`ifdef HAMMING_SECDED_EN
    localparam int FW = 8;
`else
    localparam int FW = 7;
`endif

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_DECODE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [3:0]    idle_q, idle_d;
    logic [FW-1:0] sr_q, sr_d;
    logic [FW-1:0] dec_q, dec_d;
    logic          strobe_q;
    logic [3:0]    data_q, data_d;
    logic [2:0]    pos_q, pos_d;
    logic          corr_q, corr_d;
    logic          valid_q, valid_d;
    logic          abort_q, abort_d;
    logic          accept;
    logic          last_bit;
    logic [2:0]    syn;
    logic [6:0]    fixed;
`ifdef HAMMING_SECDED_EN
    logic          dbl_q, dbl_d;
    logic          parity;
`endif

    assign accept   = strobe_in & ~strobe_q;
    assign last_bit = accept && (cnt_q == 3'(FW - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idle_q   <= '0;
            sr_q     <= '0;
            dec_q    <= '0;
            strobe_q <= 1'b0;
            data_q   <= '0;
            pos_q    <= '0;
            corr_q   <= 1'b0;
            valid_q  <= 1'b0;
            abort_q  <= 1'b0;
`ifdef HAMMING_SECDED_EN
            dbl_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idle_q   <= idle_d;
            sr_q     <= sr_d;
            dec_q    <= dec_d;
            strobe_q <= strobe_in;
            data_q   <= data_d;
            pos_q    <= pos_d;
            corr_q   <= corr_d;
            valid_q  <= valid_d;
            abort_q  <= abort_d;
`ifdef HAMMING_SECDED_EN
            dbl_q    <= dbl_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idle_d  = idle_q;
        sr_d    = sr_q;
        dec_d   = dec_q;
        abort_d = 1'b0;
        case (state_q)
            S_IDLE, S_DECODE: begin
                if (accept) begin
                    sr_d[0] = d_in;
                    cnt_d   = 3'd1;
                    idle_d  = '0;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (accept) begin
                    sr_d[cnt_q] = d_in;
                    idle_d      = '0;
                    if (last_bit) begin
                        dec_d   = sr_d;
                        cnt_d   = '0;
                        state_d = S_DECODE;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end else if (idle_q == 4'd15) begin
                    // Stalled upstream: drop the partial frame rather than mix it with the next one.
                    abort_d = 1'b1;
                    cnt_d   = '0;
                    idle_d  = '0;
                    sr_d    = '0;
                    state_d = S_IDLE;
                end else begin
                    idle_d = idle_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        syn[0] = dec_q[0] ^ dec_q[2] ^ dec_q[4] ^ dec_q[6];
        syn[1] = dec_q[1] ^ dec_q[2] ^ dec_q[5] ^ dec_q[6];
        syn[2] = dec_q[3] ^ dec_q[4] ^ dec_q[5] ^ dec_q[6];
        fixed  = dec_q[6:0];
        if (syn != 3'd0) begin
            fixed[syn - 3'd1] = ~dec_q[syn - 3'd1];
        end
        valid_d = 1'b0;
        data_d  = data_q;
        pos_d   = pos_q;
        corr_d  = corr_q;
`ifdef HAMMING_SECDED_EN
        parity  = ^dec_q;
        dbl_d   = dbl_q;
`endif
        if (state_q == S_DECODE) begin
            valid_d = 1'b1;
            pos_d   = syn;
`ifdef HAMMING_SECDED_EN
            if ((syn != 3'd0) && !parity) begin
                // Even overall parity with a nonzero syndrome: two flips, leave data raw.
                dbl_d  = 1'b1;
                corr_d = 1'b0;
                data_d = {dec_q[6], dec_q[5], dec_q[4], dec_q[2]};
            end else begin
                dbl_d  = 1'b0;
                corr_d = parity;
                data_d = {fixed[6], fixed[5], fixed[4], fixed[2]};
            end
`else
            corr_d = (syn != 3'd0);
            data_d = {fixed[6], fixed[5], fixed[4], fixed[2]};
`endif
        end
    end

    assign data_out    = data_q;
    assign valid_out   = valid_q;
    assign err_pos     = pos_q;
    assign err_corr    = corr_q;
    assign frame_abort = abort_q;
`ifdef HAMMING_SECDED_EN
    assign err_dbl     = dbl_q;
`else
    assign err_dbl     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hamming_decode_s.sv
`default_nettype none
// tb_hamming_decode_s: directed-vector bench for hamming_decode_s.
module tb_hamming_decode_s;

`ifdef HAMMING_SECDED_EN
    localparam int FW = 8;
`else
    localparam int FW = 7;
`endif

    logic       clk;
    logic       rst_n;
    logic       d_in;
    logic       strobe_in;
    logic [3:0] data_out;
    logic       valid_out;
    logic [2:0] err_pos;
    logic       err_corr;
    logic       err_dbl;
    logic       frame_abort;

    int n_cmp = 0;
    int n_err = 0;
    int vcnt  = 0;

    hamming_decode_s dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .d_in        (d_in),
        .strobe_in   (strobe_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .err_pos     (err_pos),
        .err_corr    (err_corr),
        .err_dbl     (err_dbl),
        .frame_abort (frame_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (valid_out) vcnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        d_in      = b;
        strobe_in = 1'b1;
        @(negedge clk);
        strobe_in = 1'b0;
    endtask

    task automatic run_frame(input string tag, input logic [7:0] cw, input logic [3:0] exp_d,
                             input logic [2:0] exp_pos, input logic exp_corr, input logic exp_dbl);
        int v0;
        v0 = vcnt;
        for (int i = 0; i < FW; i++) send_bit(cw[i]);
        check({tag, "_valid_early"}, valid_out, 1'b0);
        @(negedge clk);
        check({tag, "_valid"}, valid_out, 1'b1);
        check({tag, "_data"}, data_out, exp_d);
        check({tag, "_pos"}, err_pos, exp_pos);
        check({tag, "_corr"}, err_corr, exp_corr);
        check({tag, "_dbl"}, err_dbl, exp_dbl);
        repeat (3) @(negedge clk);
        check({tag, "_one_pulse"}, vcnt - v0, 1);
        check({tag, "_hold"}, data_out, exp_d);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_data"}, data_out, 4'h0);
        check({tag, "_valid"}, valid_out, 1'b0);
        check({tag, "_pos"}, err_pos, 3'd0);
        check({tag, "_corr"}, err_corr, 1'b0);
        check({tag, "_dbl"}, err_dbl, 1'b0);
        check({tag, "_abort"}, frame_abort, 1'b0);
    endtask

    initial begin
        int  v0;
        logic seen;
        rst_n     = 1'b0;
        d_in      = 1'b0;
        strobe_in = 1'b0;
        repeat (2) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Codewords are packed with c1 in bit 0; c8 (when used) is 0 for every clean frame here.
        run_frame("clean_b",  8'b0101_0101, 4'hB, 3'd0, 1'b0, 1'b0);
        run_frame("flip_c5",  8'b0100_0101, 4'hB, 3'd5, 1'b1, 1'b0);
        run_frame("flip_c1",  8'b0101_0100, 4'hB, 3'd1, 1'b1, 1'b0);
        run_frame("flip_c7",  8'b0001_0101, 4'hB, 3'd7, 1'b1, 1'b0);
        run_frame("zero",     8'b0000_0000, 4'h0, 3'd0, 1'b0, 1'b0);
        run_frame("clean_6",  8'b0011_0011, 4'h6, 3'd0, 1'b0, 1'b0);

        v0 = vcnt;
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (frame_abort) begin
                seen = 1'b1;
                break;
            end
        end
        check("abort_seen", seen, 1'b1);
        @(negedge clk);
        check("abort_one_pulse", frame_abort, 1'b0);
        check("abort_no_valid", vcnt - v0, 0);
        check("abort_hold_data", data_out, 4'h6);
        run_frame("post_abort", 8'b0101_0101, 4'hB, 3'd0, 1'b0, 1'b0);

        run_frame("flip_c2",  8'b0011_0001, 4'h6, 3'd2, 1'b1, 1'b0);

        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("mid_rst");
        repeat (2) @(negedge clk);
        check_zero_outputs("mid_rst_hold");
        rst_n = 1'b1;
        @(negedge clk);
        run_frame("post_rst", 8'b0101_0101, 4'hB, 3'd0, 1'b0, 1'b0);

`ifdef HAMMING_SECDED_EN
        run_frame("flip_c8",  8'b1101_0101, 4'hB, 3'd0, 1'b1, 1'b0);
        // c3 and c5 flipped: syndrome 6 with even overall parity; raw d bits {c7,c6,c5,c3} = 1000.
        run_frame("dbl_c3c5", 8'b0100_0001, 4'b1000, 3'd6, 1'b0, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
